// File: rtl/wm8731_cmd_scheduler.sv
// WM8731 command scheduler: sole owner of the I2C_Controller write port.
// After reset it sends the power-up table, then arbitrates mute, volume and
// user register writes, retrying NACKed transfers up to RETRY_MAX times.
//
// state | meaning
// IDLE  | no transfer in flight; arbitrates pending jobs (init first after reset)
// LOAD  | i2c_data holds the current command; i2c_go rises next cycle
// GO    | i2c_go high, waiting for i2c_end
// CHECK | i2c_go dropped, decides retry / give up / success from latched NACK
// GAP   | waits for i2c_end to fall before any new transfer
// NEXT  | advances to the next command of a multi-write job
module wm8731_cmd_scheduler #(
    parameter int          NUM_INIT  = 9,
    parameter logic [7:0]  DEV_ADDR  = 8'h34,
    parameter int          RETRY_MAX = 3
) (
    input  logic        clk_i2c,
    input  logic        reset_n,
    input  logic [1:0]  vol,
    input  logic        mute,
    input  logic        usr_req,
    input  logic [6:0]  usr_addr,
    input  logic [8:0]  usr_data,
    output logic        usr_ack,
    output logic [23:0] i2c_data,
    output logic        i2c_go,
    input  logic        i2c_end,
    input  logic [2:0]  i2c_nack,
    output logic        init_done,
    output logic        busy,
    output logic        err,
    output logic [3:0]  cmd_idx
);

    localparam int RW = $clog2(RETRY_MAX + 1);

    typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_GO, ST_CHECK, ST_GAP, ST_NEXT} state_t;
    typedef enum logic [1:0] {JOB_INIT, JOB_MUTE, JOB_VOL, JOB_USR} job_t;

    state_t        state_q, state_d;
    job_t          job_q, job_d, job_sel;
    logic [3:0]    cmd_idx_q, cmd_idx_d, nidx;
    logic          step_q, step_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          nack_q, nack_d, redo_q, redo_d;
    logic          i2c_go_q, i2c_go_d, usr_ack_q, usr_ack_d;
    logic [23:0]   i2c_data_q, i2c_data_d;
    logic          init_done_q, init_done_d, busy_q, busy_d, err_q, err_d;
    logic [1:0]    vol_applied_q, vol_applied_d, vol_lat_q, vol_lat_d;
    logic          mute_applied_q, mute_applied_d, mute_lat_q, mute_lat_d;
    logic [6:0]    usr_addr_q, usr_addr_d;
    logic [8:0]    usr_data_q, usr_data_d;
    logic          start, last_cmd;

    function automatic logic [8:0] vol_code(input logic [1:0] v);
        case (v)
            2'd0:    return 9'h039;
            2'd1:    return 9'h079;
            2'd2:    return 9'h0A9;
            default: return 9'h0E9;
        endcase
    endfunction

    function automatic logic [8:0] dig_path(input logic m);
        return m ? 9'h00E : 9'h006;
    endfunction

    // {reg[6:0], data[8:0]} for a job's command; init entries read vol/mute live
    function automatic logic [15:0] cmd_word(input job_t job, input logic [3:0] idx,
                                             input logic step, input logic [1:0] v,
                                             input logic m, input logic [6:0] a,
                                             input logic [8:0] d);
        case (job)
            JOB_INIT: begin
                case (idx)
                    4'd0:    return {7'h0F, 9'h000};
                    4'd1:    return {7'h06, 9'h000};
                    4'd2:    return {7'h08, 9'h002};
                    4'd3:    return {7'h02, vol_code(v)};
                    4'd4:    return {7'h03, vol_code(v)};
                    4'd5:    return {7'h07, 9'h001};
                    4'd6:    return {7'h09, 9'h001};
                    4'd7:    return {7'h04, 9'h016};
                    default: return {7'h05, dig_path(m)};
                endcase
            end
            JOB_MUTE: return {7'h05, dig_path(m)};
            JOB_VOL:  return step ? {7'h03, vol_code(v)} : {7'h02, vol_code(v)};
            default:  return {a, d};
        endcase
    endfunction

    // Next-state and next-output computation for the whole controller
    always_comb begin
        state_d        = state_q;
        job_d          = job_q;
        cmd_idx_d      = cmd_idx_q;
        step_d         = step_q;
        retry_d        = retry_q;
        nack_d         = nack_q;
        redo_d         = redo_q;
        i2c_go_d       = i2c_go_q;
        usr_ack_d      = 1'b0;
        i2c_data_d     = i2c_data_q;
        init_done_d    = init_done_q;
        err_d          = err_q;
        vol_applied_d  = vol_applied_q;
        mute_applied_d = mute_applied_q;
        vol_lat_d      = vol_lat_q;
        mute_lat_d     = mute_lat_q;
        usr_addr_d     = usr_addr_q;
        usr_data_d     = usr_data_q;
        start          = 1'b0;
        job_sel        = JOB_INIT;
        nidx           = cmd_idx_q + 4'd1;
        last_cmd       = 1'b1;

        case (job_q)
            JOB_INIT: last_cmd = (cmd_idx_q == 4'(NUM_INIT - 1));
            JOB_VOL:  last_cmd = step_q;
            default:  last_cmd = 1'b1;
        endcase

        case (state_q)
            ST_IDLE: begin
                // usr_req is ignored during the ack cycle so a held request is not re-run
                if (!init_done_q) begin
                    start = 1'b1; job_sel = JOB_INIT;
                end else if (mute != mute_applied_q) begin
                    start = 1'b1; job_sel = JOB_MUTE;
                end else if (vol != vol_applied_q) begin
                    start = 1'b1; job_sel = JOB_VOL;
                end else if (usr_req && !usr_ack_q) begin
                    start = 1'b1; job_sel = JOB_USR;
                end
                if (start) begin
                    state_d    = ST_LOAD;
                    job_d      = job_sel;
                    step_d     = 1'b0;
                    retry_d    = '0;
                    vol_lat_d  = vol;
                    mute_lat_d = mute;
                    usr_addr_d = usr_addr;
                    usr_data_d = usr_data;
                    if (job_sel == JOB_INIT) cmd_idx_d = 4'd0;
                    i2c_data_d = {DEV_ADDR, cmd_word(job_sel, 4'd0, 1'b0, vol, mute, usr_addr, usr_data)};
                end
            end
            ST_LOAD: begin
                state_d  = ST_GO;
                i2c_go_d = 1'b1;
            end
            ST_GO: begin
                if (i2c_end) begin
                    i2c_go_d = 1'b0;
                    nack_d   = |i2c_nack;
                    state_d  = ST_CHECK;
                end
            end
            ST_CHECK: begin
                state_d = ST_GAP;
                if (nack_q && (retry_q < RW'(RETRY_MAX))) begin
                    retry_d = retry_q + RW'(1);
                    redo_d  = 1'b1;
                end else begin
                    if (nack_q) err_d = 1'b1;
                    retry_d = '0;
                    redo_d  = 1'b0;
                end
            end
            ST_GAP: begin
                if (!i2c_end) begin
                    if (redo_q) begin
                        state_d = ST_LOAD;
                    end else if (!last_cmd) begin
                        state_d = ST_NEXT;
                    end else begin
                        state_d = ST_IDLE;
                        case (job_q)
                            JOB_INIT: begin
                                init_done_d    = 1'b1;
                                vol_applied_d  = vol_lat_q;
                                mute_applied_d = mute_lat_q;
                            end
                            JOB_MUTE: mute_applied_d = mute_lat_q;
                            JOB_VOL:  vol_applied_d  = vol_lat_q;
                            default:  usr_ack_d      = 1'b1;
                        endcase
                    end
                end
            end
            ST_NEXT: begin
                state_d = ST_LOAD;
                if (job_q == JOB_INIT) begin
                    cmd_idx_d = nidx;
                    if ((nidx == 4'd3) || (nidx == 4'd4)) vol_lat_d = vol;
                    if (nidx == 4'd8) mute_lat_d = mute;
                    i2c_data_d = {DEV_ADDR, cmd_word(JOB_INIT, nidx, 1'b0, vol, mute, usr_addr_q, usr_data_q)};
                end else begin
                    step_d     = 1'b1;
                    i2c_data_d = {DEV_ADDR, cmd_word(job_q, 4'd0, 1'b1, vol_lat_q, mute_lat_q, usr_addr_q, usr_data_q)};
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // Register state and all outputs; reset aborts any transfer immediately
    always_ff @(posedge clk_i2c or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            job_q          <= JOB_INIT;
            cmd_idx_q      <= '0;
            step_q         <= 1'b0;
            retry_q        <= '0;
            nack_q         <= 1'b0;
            redo_q         <= 1'b0;
            i2c_go_q       <= 1'b0;
            usr_ack_q      <= 1'b0;
            i2c_data_q     <= '0;
            init_done_q    <= 1'b0;
            busy_q         <= 1'b0;
            err_q          <= 1'b0;
            vol_applied_q  <= '0;
            mute_applied_q <= 1'b0;
            vol_lat_q      <= '0;
            mute_lat_q     <= 1'b0;
            usr_addr_q     <= '0;
            usr_data_q     <= '0;
        end else begin
            state_q        <= state_d;
            job_q          <= job_d;
            cmd_idx_q      <= cmd_idx_d;
            step_q         <= step_d;
            retry_q        <= retry_d;
            nack_q         <= nack_d;
            redo_q         <= redo_d;
            i2c_go_q       <= i2c_go_d;
            usr_ack_q      <= usr_ack_d;
            i2c_data_q     <= i2c_data_d;
            init_done_q    <= init_done_d;
            busy_q         <= busy_d;
            err_q          <= err_d;
            vol_applied_q  <= vol_applied_d;
            mute_applied_q <= mute_applied_d;
            vol_lat_q      <= vol_lat_d;
            mute_lat_q     <= mute_lat_d;
            usr_addr_q     <= usr_addr_d;
            usr_data_q     <= usr_data_d;
        end
    end

    assign usr_ack   = usr_ack_q;
    assign i2c_data  = i2c_data_q;
    assign i2c_go    = i2c_go_q;
    assign init_done = init_done_q;
    assign busy      = busy_q;
    assign err       = err_q;
    assign cmd_idx   = cmd_idx_q;

endmodule

// File: tb/tb_wm8731_cmd_scheduler.sv
// Directed bench for wm8731_cmd_scheduler with a simple I2C_Controller model
// that logs every transfer and can NACK a chosen command a set number of times.
module tb_wm8731_cmd_scheduler;

    logic        clk_i2c = 1'b0;
    logic        reset_n;
    logic [1:0]  vol;
    logic        mute;
    logic        usr_req;
    logic [6:0]  usr_addr;
    logic [8:0]  usr_data;
    logic        usr_ack;
    logic [23:0] i2c_data;
    logic        i2c_go;
    logic        i2c_end;
    logic [2:0]  i2c_nack;
    logic        init_done;
    logic        busy;
    logic        err;
    logic [3:0]  cmd_idx;

    int          checks = 0;
    int          errors = 0;
    logic [23:0] log_d [0:31];
    int          log_n = 0;
    int          ack_cnt = 0;
    int          busy_bad = 0;
    logic        model_busy = 1'b0;
    logic [23:0] nack_match = 24'h0;
    int          nack_left = 0;
    logic [23:0] exp_w [0:15];

    wm8731_cmd_scheduler dut (
        .clk_i2c  (clk_i2c),
        .reset_n  (reset_n),
        .vol      (vol),
        .mute     (mute),
        .usr_req  (usr_req),
        .usr_addr (usr_addr),
        .usr_data (usr_data),
        .usr_ack  (usr_ack),
        .i2c_data (i2c_data),
        .i2c_go   (i2c_go),
        .i2c_end  (i2c_end),
        .i2c_nack (i2c_nack),
        .init_done(init_done),
        .busy     (busy),
        .err      (err),
        .cmd_idx  (cmd_idx)
    );

    always #5 clk_i2c = ~clk_i2c;

    function automatic logic [23:0] wr(input logic [6:0] r, input logic [8:0] d);
        return {8'h34, r, d};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Wait until the DUT and model have been quiet for 4 consecutive cycles
    task automatic wait_done(input string tag);
        int n = 0;
        int quiet = 0;
        while (quiet < 4 && n < 600) begin
            @(negedge clk_i2c);
            n++;
            if (busy || i2c_end || model_busy) quiet = 0;
            else quiet++;
        end
        check({tag, "_timeout"}, 32'(n < 600), 32'd1);
    endtask

    task automatic wait_go(input string tag);
        int n = 0;
        while (!i2c_go && n < 100) begin
            @(negedge clk_i2c);
            n++;
        end
        check({tag, "_go_timeout"}, 32'(n < 100), 32'd1);
    endtask

    task automatic cmp_log(input string tag, input int n);
        check({tag, "_count"}, 32'(log_n), 32'(n));
        for (int i = 0; i < n && i < 32; i++)
            check($sformatf("%s_w%0d", tag, i), 32'(log_d[i]), 32'(exp_w[i]));
    endtask

    // I2C_Controller model: end after 2 cycles, held until go drops, then one more cycle
    initial begin
        i2c_end  = 1'b0;
        i2c_nack = 3'b000;
        forever begin
            @(negedge clk_i2c);
            if (i2c_go && !i2c_end) begin
                int w = 0;
                model_busy = 1'b1;
                if (!busy) busy_bad++;
                if (log_n < 32) log_d[log_n] = i2c_data;
                log_n++;
                repeat (2) @(negedge clk_i2c);
                if (nack_left > 0 && i2c_data == nack_match) begin
                    i2c_nack  = 3'b010;
                    nack_left--;
                end
                i2c_end = 1'b1;
                while (i2c_go && w < 50) begin
                    @(negedge clk_i2c);
                    w++;
                end
                @(negedge clk_i2c);
                i2c_end    = 1'b0;
                i2c_nack   = 3'b000;
                model_busy = 1'b0;
            end
        end
    end

    // Count ack pulses and drop the user request as soon as it is acknowledged
    initial begin
        forever begin
            @(negedge clk_i2c);
            if (usr_ack) begin
                ack_cnt++;
                usr_req = 1'b0;
            end
        end
    end

    initial begin
        reset_n  = 1'b0;
        vol      = 2'd1;
        mute     = 1'b0;
        usr_req  = 1'b0;
        usr_addr = 7'h00;
        usr_data = 9'h000;
        repeat (3) @(negedge clk_i2c);
        check("rst_go", 32'(i2c_go), 32'd0);
        check("rst_data", 32'(i2c_data), 32'd0);
        check("rst_ack", 32'(usr_ack), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_cmd_idx", 32'(cmd_idx), 32'd0);

        // Power-up table with vol=1, mute=0
        reset_n = 1'b1;
        @(negedge clk_i2c);
        check("lat_go_low", 32'(i2c_go), 32'd0);
        check("lat_data_first", 32'(i2c_data), 32'(wr(7'h0F, 9'h000)));
        @(negedge clk_i2c);
        check("lat_go_high", 32'(i2c_go), 32'd1);
        exp_w[0] = wr(7'h0F, 9'h000);
        exp_w[1] = wr(7'h06, 9'h000);
        exp_w[2] = wr(7'h08, 9'h002);
        exp_w[3] = wr(7'h02, 9'h079);
        exp_w[4] = wr(7'h03, 9'h079);
        exp_w[5] = wr(7'h07, 9'h001);
        exp_w[6] = wr(7'h09, 9'h001);
        exp_w[7] = wr(7'h04, 9'h016);
        exp_w[8] = wr(7'h05, 9'h006);
        wait_done("init");
        cmp_log("init", 9);
        check("init_done", 32'(init_done), 32'd1);
        check("init_err", 32'(err), 32'd0);
        check("init_cmd_idx", 32'(cmd_idx), 32'd8);

        // Volume change 1 -> 3
        log_n = 0;
        vol = 2'd3;
        wait_done("vol");
        exp_w[0] = wr(7'h02, 9'h0E9);
        exp_w[1] = wr(7'h03, 9'h0E9);
        cmp_log("vol", 2);

        // Mute and user request together: mute wins
        log_n = 0;
        ack_cnt = 0;
        mute = 1'b1;
        usr_addr = 7'h04;
        usr_data = 9'h012;
        usr_req = 1'b1;
        wait_done("mute_usr");
        exp_w[0] = wr(7'h05, 9'h00E);
        exp_w[1] = wr(7'h04, 9'h012);
        cmp_log("mute_usr", 2);
        check("mute_usr_ack", 32'(ack_cnt), 32'd1);

        // Volume toggled away and back during a user job: no volume write
        log_n = 0;
        ack_cnt = 0;
        usr_addr = 7'h07;
        usr_data = 9'h00A;
        usr_req = 1'b1;
        wait_go("toggle");
        vol = 2'd0;
        repeat (2) @(negedge clk_i2c);
        vol = 2'd3;
        wait_done("toggle");
        exp_w[0] = wr(7'h07, 9'h00A);
        cmp_log("toggle", 1);
        check("toggle_ack", 32'(ack_cnt), 32'd1);
        check("busy_during_xfer", 32'(busy_bad), 32'd0);

        // Reset mid-transfer of a volume job, then init with NACKs on entry 2
        log_n = 0;
        vol = 2'd1;
        wait_go("rst_mid");
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_go", 32'(i2c_go), 32'd0);
        check("rst_mid_cmd_idx", 32'(cmd_idx), 32'd0);
        check("rst_mid_init_done", 32'(init_done), 32'd0);
        repeat (6) @(negedge clk_i2c);
        log_n = 0;
        nack_match = wr(7'h08, 9'h002);
        nack_left = 4;
        reset_n = 1'b1;
        wait_done("nack");
        exp_w[0]  = wr(7'h0F, 9'h000);
        exp_w[1]  = wr(7'h06, 9'h000);
        exp_w[2]  = wr(7'h08, 9'h002);
        exp_w[3]  = wr(7'h08, 9'h002);
        exp_w[4]  = wr(7'h08, 9'h002);
        exp_w[5]  = wr(7'h08, 9'h002);
        exp_w[6]  = wr(7'h02, 9'h079);
        exp_w[7]  = wr(7'h03, 9'h079);
        exp_w[8]  = wr(7'h07, 9'h001);
        exp_w[9]  = wr(7'h09, 9'h001);
        exp_w[10] = wr(7'h04, 9'h016);
        exp_w[11] = wr(7'h05, 9'h00E);
        cmp_log("nack", 12);
        check("nack_err", 32'(err), 32'd1);
        check("nack_init_done", 32'(init_done), 32'd1);
        check("nack_cmd_idx", 32'(cmd_idx), 32'd8);
        repeat (20) @(negedge clk_i2c);
        check("nack_no_extra", 32'(log_n), 32'd12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
